// File: rtl/trng_pkg.sv
// trng_pkg
// Shared types and default sizes for the TRNG measurement blocks.
// Contents:
//   pm_state_t  - period_meter FSM states (IDLE, ARM, MEASURE, DONE)
//   PM_CNT_W    - default width of the per-half-period cycle counter
//   PM_LOG2_HP  - default log2 of the number of half-periods summed per measurement
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } pm_state_t;

  localparam int PM_CNT_W   = 16;
  localparam int PM_LOG2_HP = 3;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
// Brings an asynchronous level into the clock domain via a 2-FF synchroniser, then
// flags either polarity of transition by comparing with a third, delayed copy.
// A change on d_i appears on edge_o two clocks later and is registered by the
// consumer on the third clock.
// Ports:
//   clk_i   in   1  system clock, rising edge
//   rst_ni  in   1  asynchronous, active-low reset
//   d_i     in   1  asynchronous input level
//   edge_o  out  1  one-cycle pulse on any synchronised transition of d_i
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // s1/s2 form the metastability synchroniser; s3 is only a delay for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_o = s2_q ^ s3_q;

endmodule

// File: rtl/period_meter.sv
// period_meter
// Measures the toggle rate of a slow square wave against clk by summing NUM_HP
// consecutive half-periods, expressed in clk cycles. The first edge after start only
// sets the timing reference. A half-period that reaches the counter limit without an
// edge aborts the measurement with overflow set and the partial sum held.
// Optional feature (macro PERIOD_METER_MINMAX_EN): min_hp/max_hp ports report the
// shortest and longest half-period of the measurement for jitter statistics.
// Parameters:
//   CNT_W    per-half-period counter width
//   LOG2_HP  NUM_HP = 2**LOG2_HP half-periods per measurement
//   SUM_W    derived result width, CNT_W + LOG2_HP
// Ports:
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous, active-low reset
//   sig_in    in   1      asynchronous square wave under measurement
//   start     in   1      one-cycle request to begin a measurement
//   ack       in   1      consumer has taken the result
//   busy      out  1      high in ARM and MEASURE
//   valid     out  1      result held stable while high
//   sum       out  SUM_W  sum of NUM_HP half-periods in clk cycles
//   overflow  out  1      measurement aborted by timeout, qualified by valid
//   min_hp    out  CNT_W  (MINMAX only) shortest half-period seen
//   max_hp    out  CNT_W  (MINMAX only) longest half-period seen
module period_meter
  import trng_pkg::*;
#(
  parameter  int CNT_W   = PM_CNT_W,
  parameter  int LOG2_HP = PM_LOG2_HP,
  localparam int SUM_W   = CNT_W + LOG2_HP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [SUM_W-1:0] sum,
  output logic             overflow
`ifdef PERIOD_METER_MINMAX_EN
  ,
  output logic [CNT_W-1:0] min_hp,
  output logic [CNT_W-1:0] max_hp
`endif
);

  localparam logic [CNT_W-1:0]   HP_MAX    = '1;
  localparam logic [LOG2_HP-1:0] LAST_EDGE = '1;

  pm_state_t          state_q, state_d;
  logic [CNT_W-1:0]   hpCnt_q, hpCnt_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [LOG2_HP-1:0] edgeCnt_q, edgeCnt_d;
  logic               overflow_q, overflow_d;

  logic               edgeDet;
  logic               clearRun;
  logic               hpClosed;
  logic [SUM_W-1:0]   hpLen;

  sync_edge_det uSync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (sig_in),
    .edge_o (edgeDet)
  );

  // Length of the half-period that closes on this cycle's edge, widened so it cannot wrap.
  assign hpLen = SUM_W'(hpCnt_q) + SUM_W'(1);

  // State, counter, accumulator and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hpCnt_q    <= '0;
      sum_q      <= '0;
      edgeCnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hpCnt_q    <= hpCnt_d;
      sum_q      <= sum_d;
      edgeCnt_q  <= edgeCnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic. An edge always takes priority over the timeout check, so a
  // half-period of exactly 2**CNT_W cycles is still counted.
  always_comb begin
    state_d    = state_q;
    hpCnt_d    = hpCnt_q;
    sum_d      = sum_q;
    edgeCnt_d  = edgeCnt_q;
    overflow_d = overflow_q;
    clearRun   = 1'b0;
    hpClosed   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ARM;
          clearRun = 1'b1;
        end
      end

      ARM: begin
        if (edgeDet) begin
          hpCnt_d = '0;
          state_d = MEASURE;
        end else if (hpCnt_q == HP_MAX) begin
          state_d    = DONE;
          overflow_d = 1'b1;
        end else begin
          hpCnt_d = hpCnt_q + CNT_W'(1);
        end
      end

      MEASURE: begin
        if (edgeDet) begin
          hpClosed  = 1'b1;
          sum_d     = sum_q + hpLen;
          hpCnt_d   = '0;
          edgeCnt_d = edgeCnt_q + LOG2_HP'(1);
          if (edgeCnt_q == LAST_EDGE) begin
            state_d = DONE;
          end
        end else if (hpCnt_q == HP_MAX) begin
          state_d    = DONE;
          overflow_d = 1'b1;
        end else begin
          hpCnt_d = hpCnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (start) begin
          state_d  = ARM;
          clearRun = 1'b1;
        end else if (ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (clearRun) begin
      hpCnt_d    = '0;
      sum_d      = '0;
      edgeCnt_d  = '0;
      overflow_d = 1'b0;
    end
  end

  assign busy     = (state_q == ARM) || (state_q == MEASURE);
  assign valid    = (state_q == DONE);
  assign sum      = sum_q;
  assign overflow = overflow_q;

`ifdef PERIOD_METER_MINMAX_EN
  logic [CNT_W-1:0] minHp_q, minHp_d;
  logic [CNT_W-1:0] maxHp_q, maxHp_d;
  logic [CNT_W-1:0] hpLenSat;

  // A full 2**CNT_W half-period does not fit CNT_W bits, so it saturates to all ones.
  assign hpLenSat = (hpCnt_q == HP_MAX) ? HP_MAX : (hpCnt_q + CNT_W'(1));

  // Min/max statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minHp_q <= '1;
      maxHp_q <= '0;
    end else begin
      minHp_q <= minHp_d;
      maxHp_q <= maxHp_d;
    end
  end

  // Restart on entry to ARM, fold in each closed half-period during MEASURE.
  always_comb begin
    minHp_d = minHp_q;
    maxHp_d = maxHp_q;
    if (clearRun) begin
      minHp_d = '1;
      maxHp_d = '0;
    end else if (hpClosed) begin
      if (hpLenSat < minHp_q) minHp_d = hpLenSat;
      if (hpLenSat > maxHp_q) maxHp_d = hpLenSat;
    end
  end

  assign min_hp = minHp_q;
  assign max_hp = maxHp_q;
`endif

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter
// Directed self-checking bench for period_meter, built with CNT_W=8 and LOG2_HP=3 so
// the counter limit is reachable quickly. sig_in is toggled on falling clk edges at
// hand-chosen spacings; outputs are sampled on falling edges.
// Build with PERIOD_METER_MINMAX_EN defined to also exercise min_hp/max_hp.
`timescale 1ns/1ps
module tb_period_meter;

  localparam int CNT_W   = 8;
  localparam int LOG2_HP = 3;
  localparam int SUM_W   = CNT_W + LOG2_HP;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b1;
  logic             sig_in = 1'b0;
  logic             start  = 1'b0;
  logic             ack    = 1'b0;
  logic             busy;
  logic             valid;
  logic [SUM_W-1:0] sum;
  logic             overflow;
`ifdef PERIOD_METER_MINMAX_EN
  logic [CNT_W-1:0] min_hp;
  logic [CNT_W-1:0] max_hp;
`endif

  int assertCount = 0;
  int failCount   = 0;
  int cyc;

  // 10 ns system clock.
  always #5 clk = ~clk;

  period_meter #(
    .CNT_W   (CNT_W),
    .LOG2_HP (LOG2_HP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .start    (start),
    .ack      (ack),
    .busy     (busy),
    .valid    (valid),
    .sum      (sum),
    .overflow (overflow)
`ifdef PERIOD_METER_MINMAX_EN
    ,
    .min_hp   (min_hp),
    .max_hp   (max_hp)
`endif
  );

  // One comparison: count it, and on mismatch count and report the failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Toggle sig_in after hp falling edges, giving a half-period of exactly hp clk cycles.
  task automatic applyStimulus(input int hp);
    repeat (hp) @(negedge clk);
    sig_in = ~sig_in;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulseAck();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Bounded wait for valid; the caller checks valid afterwards to catch an expiry.
  task automatic waitValid(input int limit, output int cycles);
    cycles = 0;
    while (!valid && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    // Reset state.
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_overflow", overflow, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Divider loopback, divisor 5: eight half-periods of 6 -> 48.
    pulseStart();
    checkOutput("arm_busy", busy, 1);
    applyStimulus(3);
    for (int i = 0; i < 8; i++) applyStimulus(6);
    repeat (2) @(negedge clk);
    checkOutput("latency_early", valid, 0);
    repeat (2) @(negedge clk);
    checkOutput("latency_valid", valid, 1);
    checkOutput("div5_sum", sum, 48);
    checkOutput("div5_overflow", overflow, 0);
    checkOutput("done_busy", busy, 0);
    applyStimulus(4);
    repeat (4) @(negedge clk);
    checkOutput("hold_sum", sum, 48);
    checkOutput("hold_valid", valid, 1);
    pulseAck();
    checkOutput("ack_valid", valid, 0);
    checkOutput("ack_busy", busy, 0);
    repeat (3) @(negedge clk);

    // Stuck sig_in: ARM times out once hp_cnt reaches 255.
    pulseStart();
    waitValid(400, cyc);
    checkOutput("stuck_valid", valid, 1);
    checkOutput("stuck_cycles", cyc, 256);
    checkOutput("stuck_overflow", overflow, 1);
    checkOutput("stuck_sum", sum, 0);

    // start and ack together in DONE: restart wins.
    start = 1'b1;
    ack   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b0;
    checkOutput("restart_valid", valid, 0);
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_sum", sum, 0);
    checkOutput("restart_overflow", overflow, 0);

    // Mixed divisors 5 then 9, with an ignored start mid-run: 4*6 + 4*10 = 64.
    applyStimulus(3);
    for (int i = 0; i < 4; i++) applyStimulus(6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    applyStimulus(9);
    for (int i = 0; i < 3; i++) applyStimulus(10);
    waitValid(20, cyc);
    checkOutput("mixed_valid", valid, 1);
    checkOutput("mixed_sum", sum, 64);
    checkOutput("mixed_overflow", overflow, 0);
    pulseAck();

    // Edge on the same cycle as the timeout: 256 + 7*6 = 298, no overflow.
    pulseStart();
    applyStimulus(3);
    applyStimulus(256);
    for (int i = 0; i < 7; i++) applyStimulus(6);
    waitValid(20, cyc);
    checkOutput("edge_wins_valid", valid, 1);
    checkOutput("edge_wins_sum", sum, 298);
    checkOutput("edge_wins_overflow", overflow, 0);
    pulseAck();

    // Timeout during MEASURE keeps the partial sum: 2*6 = 12.
    pulseStart();
    applyStimulus(3);
    applyStimulus(6);
    applyStimulus(6);
    waitValid(400, cyc);
    checkOutput("partial_valid", valid, 1);
    checkOutput("partial_overflow", overflow, 1);
    checkOutput("partial_sum", sum, 12);
    pulseAck();

    // Reset mid-MEASURE is asynchronous; the next run is clean.
    pulseStart();
    applyStimulus(3);
    for (int i = 0; i < 3; i++) applyStimulus(6);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_valid", valid, 0);
    checkOutput("midrst_sum", sum, 0);
    checkOutput("midrst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    pulseStart();
    applyStimulus(3);
    for (int i = 0; i < 8; i++) applyStimulus(6);
    waitValid(20, cyc);
    checkOutput("after_rst_valid", valid, 1);
    checkOutput("after_rst_sum", sum, 48);
    checkOutput("after_rst_overflow", overflow, 0);
    pulseAck();

`ifdef PERIOD_METER_MINMAX_EN
    // Alternating half-periods 5 and 7.
    pulseStart();
    checkOutput("mm_clear_min", min_hp, 255);
    checkOutput("mm_clear_max", max_hp, 0);
    applyStimulus(3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5);
      applyStimulus(7);
    end
    waitValid(20, cyc);
    checkOutput("mm_valid", valid, 1);
    checkOutput("mm_sum", sum, 48);
    checkOutput("mm_min", min_hp, 5);
    checkOutput("mm_max", max_hp, 7);
    pulseAck();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
